bcd_serial_alu: RTL and testbench

Parametrised, sequential, digit-serial BCD add/subtract unit that succeeds the fixed two-digit combinational BCD adder used in the term-project calculator. It takes two NDIGITS-wide packed-BCD operands and a mode bit, processes one decimal digit per clock (least significant first) with a start/done handshake, and returns a registered BCD result. It adds signed subtraction via 10's complement with a recomplement pass, and flags invalid (non-BCD) operands. It sits between the switch/operand capture logic and the seven-segment decode logic.

---
 rtl/bcd_serial_alu_if.sv | 26 ++
 rtl/bcd_serial_alu.sv | 175 +++++++++++++++++
 tb/tb_bcd_serial_alu.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_alu_if.sv
// Handshake and operand/result bundle for the digit-serial BCD ALU.
// master drives the request side, slave returns the registered result.
interface bcd_serial_alu_if #(
    parameter int NDIGITS = 4
) ();
    logic                   START;
    logic                   SUB;
    logic [4*NDIGITS-1:0]   A;
    logic [4*NDIGITS-1:0]   B;
    logic                   BUSY;
    logic                   DONE;
    logic [4*NDIGITS-1:0]   RESULT;
    logic                   COUT;
    logic                   NEG;
    logic                   INVALID;

    modport master (
        output START, SUB, A, B,
        input  BUSY, DONE, RESULT, COUT, NEG, INVALID
    );

    modport slave (
        input  START, SUB, A, B,
        output BUSY, DONE, RESULT, COUT, NEG, INVALID
    );
endinterface

// File: rtl/bcd_serial_alu.sv
// Digit-serial packed-BCD add/subtract, one digit per clock, LSD first.
// Subtraction uses 10's complement with a recomplement pass when A<B.
module bcd_serial_alu #(
    parameter int NDIGITS = 4
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    bcd_serial_alu_if.slave  bus
);
    localparam int W  = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t                   r_state, w_state;
    logic [IW-1:0]            r_idx, w_idx;
    logic                     r_c, w_c;
    logic                     r_sub, w_sub;
    logic                     r_bad, w_bad;
    logic [NDIGITS-1:0][3:0]  r_a, w_a;
    logic [NDIGITS-1:0][3:0]  r_b, w_b;
    logic [NDIGITS-1:0][3:0]  r_p, w_p;
    logic [NDIGITS-1:0][3:0]  w_pn;
    logic [W-1:0]             r_res, w_res;
    logic                     r_cout, w_cout;
    logic                     r_neg, w_neg;
    logic                     r_inv, w_inv;
    logic                     r_busy, r_done;
    logic [3:0]               w_ad, w_bd, w_dig;
    logic [4:0]               w_t;
    logic                     w_carry, w_last;

    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++)
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // Shared digit adder: CALC adds A + (B or 9-B), FIX complements the partial.
    always_comb begin
        w_ad    = (r_state == S_FIX) ? 4'd0 : r_a[r_idx];
        if (r_state == S_FIX)
            w_bd = 4'd9 - r_p[r_idx];
        else if (r_sub)
            w_bd = 4'd9 - r_b[r_idx];
        else
            w_bd = r_b[r_idx];
        w_t     = {1'b0, w_ad} + {1'b0, w_bd} + {4'd0, r_c};
        w_carry = (w_t >= 5'd10);
        w_dig   = w_carry ? w_t[3:0] - 4'd10 : w_t[3:0];
        w_pn    = r_p;
        w_pn[r_idx] = w_dig;
        w_last  = (r_idx == IW'(NDIGITS - 1));
    end

    // Next-state and next-datapath decode; results move only on entry to DONE.
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_c     = r_c;
        w_sub   = r_sub;
        w_bad   = r_bad;
        w_a     = r_a;
        w_b     = r_b;
        w_p     = r_p;
        w_res   = r_res;
        w_cout  = r_cout;
        w_neg   = r_neg;
        w_inv   = r_inv;
        unique case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_a     = bus.A;
                    w_b     = bus.B;
                    w_sub   = bus.SUB;
                    w_bad   = has_bad(bus.A) | has_bad(bus.B);
                    w_idx   = '0;
                    w_c     = bus.SUB;
                    w_p     = '0;
                    w_state = S_CALC;
                end
            end
            S_CALC: begin
                if (r_bad) begin
                    w_state = S_DONE;
                    w_res   = '0;
                    w_cout  = 1'b0;
                    w_neg   = 1'b0;
                    w_inv   = 1'b1;
                end else begin
                    w_p   = w_pn;
                    w_c   = w_carry;
                    w_idx = r_idx + 1'b1;
                    if (w_last) begin
                        w_idx = '0;
                        if (r_sub && !w_carry) begin
                            w_c     = 1'b1;
                            w_state = S_FIX;
                        end else begin
                            w_state = S_DONE;
                            w_res   = w_pn;
                            w_cout  = !r_sub && w_carry;
                            w_neg   = 1'b0;
                            w_inv   = 1'b0;
                        end
                    end
                end
            end
            S_FIX: begin
                w_p   = w_pn;
                w_c   = w_carry;
                w_idx = r_idx + 1'b1;
                if (w_last) begin
                    w_idx   = '0;
                    w_state = S_DONE;
                    w_res   = w_pn;
                    w_cout  = 1'b0;
                    w_neg   = 1'b1;
                    w_inv   = 1'b0;
                end
            end
            S_DONE: w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs; async reset aborts any operation.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_c     <= 1'b0;
            r_sub   <= 1'b0;
            r_bad   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_neg   <= 1'b0;
            r_inv   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_c     <= w_c;
            r_sub   <= w_sub;
            r_bad   <= w_bad;
            r_a     <= w_a;
            r_b     <= w_b;
            r_p     <= w_p;
            r_res   <= w_res;
            r_cout  <= w_cout;
            r_neg   <= w_neg;
            r_inv   <= w_inv;
            r_busy  <= (w_state != S_IDLE);
            r_done  <= (w_state == S_DONE);
        end
    end

    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
    assign bus.RESULT  = r_res;
    assign bus.COUT    = r_cout;
    assign bus.NEG     = r_neg;
    assign bus.INVALID = r_inv;
endmodule

// File: tb/tb_bcd_serial_alu.sv
// Scoreboard bench for bcd_serial_alu: 2-digit and 4-digit instances.
// Stimulus pushes expected results; a negedge monitor pops on DONE.
module tb_bcd_serial_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_serial_alu_if #(.NDIGITS(2)) b2 ();
    bcd_serial_alu_if #(.NDIGITS(4)) b4 ();

    bcd_serial_alu #(.NDIGITS(2)) dut2 (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (b2)
    );

    bcd_serial_alu #(.NDIGITS(4)) dut4 (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (b4)
    );

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ng;
        logic        inv;
        int          acc;
        int          lat;
        string       nm;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (b2.DONE) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done2: got DONE=1 want none");
            end else begin
                e = q2.pop_front();
                cmp({e.nm, ".res"}, 32'(b2.RESULT), 32'(e.res[7:0]));
                cmp({e.nm, ".cout"}, 32'(b2.COUT), 32'(e.co));
                cmp({e.nm, ".neg"}, 32'(b2.NEG), 32'(e.ng));
                cmp({e.nm, ".inv"}, 32'(b2.INVALID), 32'(e.inv));
                cmp({e.nm, ".lat"}, 32'(cyc - e.acc), 32'(e.lat));
                cmp({e.nm, ".busy"}, 32'(b2.BUSY), 32'd1);
            end
        end
        if (b4.DONE) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done4: got DONE=1 want none");
            end else begin
                e = q4.pop_front();
                cmp({e.nm, ".res"}, 32'(b4.RESULT), 32'(e.res));
                cmp({e.nm, ".cout"}, 32'(b4.COUT), 32'(e.co));
                cmp({e.nm, ".neg"}, 32'(b4.NEG), 32'(e.ng));
                cmp({e.nm, ".inv"}, 32'(b4.INVALID), 32'(e.inv));
                cmp({e.nm, ".lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input bit d4, input logic [15:0] a,
                         input logic [15:0] b, input bit sub,
                         input logic [15:0] r, input bit co, input bit ng,
                         input bit inv, input int lat, input string nm,
                         input bit push);
        exp_t e;
        @(negedge clk);
        if (d4) begin
            b4.START = 1'b1;
            b4.A = a;
            b4.B = b;
            b4.SUB = sub;
        end else begin
            b2.START = 1'b1;
            b2.A = a[7:0];
            b2.B = b[7:0];
            b2.SUB = sub;
        end
        @(posedge clk);
        #1;
        e.res = r;
        e.co  = co;
        e.ng  = ng;
        e.inv = inv;
        e.acc = cyc;
        e.lat = lat;
        e.nm  = nm;
        if (push) begin
            if (d4) q4.push_back(e);
            else q2.push_back(e);
        end
        b2.START = 1'b0;
        b4.START = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q2.size() == 0 && q4.size() == 0) break;
        end
        if (q2.size() != 0 || q4.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending want 0",
                     q2.size() + q4.size());
            q2.delete();
            q4.delete();
        end
    endtask

    initial begin : stim
        exp_t e;
        b2.START = 1'b0; b2.SUB = 1'b0; b2.A = '0; b2.B = '0;
        b4.START = 1'b0; b4.SUB = 1'b0; b4.A = '0; b4.B = '0;
        repeat (2) @(negedge clk);
        cmp("rst.busy", 32'(b2.BUSY), 32'd0);
        cmp("rst.done", 32'(b2.DONE), 32'd0);
        cmp("rst.res", 32'(b2.RESULT), 32'd0);
        cmp("rst.cout", 32'(b2.COUT), 32'd0);
        cmp("rst.neg", 32'(b2.NEG), 32'd0);
        cmp("rst.inv", 32'(b2.INVALID), 32'd0);
        rst_n = 1'b1;

        issue(0, 16'h47, 16'h38, 0, 16'h85, 0, 0, 0, 2, "add47_38", 1);
        wait_idle();
        issue(0, 16'h99, 16'h01, 0, 16'h00, 1, 0, 0, 2, "add99_01", 1);
        wait_idle();
        issue(0, 16'h99, 16'h99, 0, 16'h98, 1, 0, 0, 2, "add99_99", 1);
        wait_idle();
        issue(0, 16'h52, 16'h17, 1, 16'h35, 0, 0, 0, 2, "sub52_17", 1);
        wait_idle();
        issue(0, 16'h17, 16'h52, 1, 16'h35, 0, 1, 0, 4, "sub17_52", 1);
        wait_idle();
        issue(0, 16'h40, 16'h40, 1, 16'h00, 0, 0, 0, 2, "sub40_40", 1);
        wait_idle();
        issue(0, 16'h1A, 16'h05, 0, 16'h00, 0, 0, 1, 1, "inv1A_05", 1);
        wait_idle();
        issue(0, 16'h12, 16'h34, 0, 16'h46, 0, 0, 0, 2, "add12_34", 1);
        wait_idle();

        @(negedge clk);
        b2.START = 1'b1;
        b2.A = 8'h47;
        b2.B = 8'h38;
        b2.SUB = 1'b0;
        @(posedge clk);
        #1;
        e.res = 16'h85; e.co = 1'b0; e.ng = 1'b0; e.inv = 1'b0;
        e.acc = cyc; e.lat = 2; e.nm = "hold";
        q2.push_back(e);
        b2.A = 8'h11;
        b2.B = 8'h22;
        b2.SUB = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b2.DONE) break;
        end
        b2.START = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        issue(0, 16'h25, 16'h25, 0, 16'h00, 0, 0, 0, 2, "aborted", 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("midrst.busy", 32'(b2.BUSY), 32'd0);
        cmp("midrst.done", 32'(b2.DONE), 32'd0);
        cmp("midrst.res", 32'(b2.RESULT), 32'd0);
        cmp("midrst.cout", 32'(b2.COUT), 32'd0);
        cmp("midrst.neg", 32'(b2.NEG), 32'd0);
        cmp("midrst.inv", 32'(b2.INVALID), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(0, 16'h25, 16'h25, 0, 16'h50, 0, 0, 0, 2, "postrst", 1);
        wait_idle();

        issue(1, 16'h0000, 16'h0001, 1, 16'h0001, 0, 1, 0, 8, "w4sub", 1);
        wait_idle();
        issue(1, 16'h1234, 16'h8766, 0, 16'h0000, 1, 0, 0, 4, "w4add", 1);
        wait_idle();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
